// File: rtl/vid_src_switch_pkg.sv
// Shared video types for the source switch: pixel format, switch FSM states
// and the fixed pipeline latency of the block.
package vid_src_switch_pkg;

  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    SRC_RUN,
    SRC_PEND,
    SRC_BLANK
  } src_sw_state_e;

  localparam int SRC_SWITCH_LAT = 1;

endpackage

// File: rtl/vid_src_switch_if.sv
// Video sideband bundle (de/x/y/sof/eol) travelling alongside the pixels.
// The timing generator drives it through the master modport; consumers use slave.
interface vid_sideband_if #(
  parameter int XW = 10,
  parameter int YW = 9
);

  logic          de;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          sof;
  logic          eol;

  modport master (output de, x, y, sof, eol);
  modport slave  (input  de, x, y, sof, eol);

endinterface

// File: rtl/vid_src_switch_sync_delay.sv
// Generic register delay line, cleared to zero by the synchronous reset.
// Used for the raw syncs and for the sideband so every path sees the same latency.
module vid_sync_delay #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (LAT == 0) begin : g_bypass
      assign q = d;
    end else begin : g_pipe
      logic [W-1:0] stage [LAT];

      // Shift the input through LAT stages; reset clears every stage
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/vid_src_switch.sv
// N-way video source selector with frame-aligned switching.
// A source change is held pending until the next sof so frames are never torn.
// Pixels, sideband and hs/vs all leave exactly one clock after they arrive.
// Optional feature macro: VID_SRC_SWITCH_BLANK_EN inserts one black frame
// between the old and the new source.
module vid_src_switch
  import vid_src_switch_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int DEF_SRC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pixel_t                     px_in [N_SRC],
  vid_sideband_if.slave              sb_in,
  input  logic                       hs_i,
  input  logic                       vs_i,
  input  logic [$clog2(N_SRC)-1:0]   sel_req,
  output pixel_t                     px_out,
  vid_sideband_if.master             sb_out,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic [$clog2(N_SRC)-1:0]   active_sel_o,
  output logic                       pending_o,
  output logic [15:0]                frame_cnt_o
);

  localparam int SW  = $clog2(N_SRC);
  localparam int SBW = XW + YW + 3;
  localparam logic [SW-1:0] DEF_SEL = SW'(DEF_SRC);

  src_sw_state_e state_q, state_d;
  logic [SW-1:0] active_q, active_d;
  logic [SW-1:0] pend_q, pend_d;
  logic          req_valid;
  logic          blank_now;
  pixel_t        px_next;
  logic [15:0]   frame_cnt_q;
  logic [SBW-1:0] sb_dly;
  logic [1:0]     sync_dly;

  // Requests naming a non-existent source are simply ignored
  assign req_valid = (32'(sel_req) < 32'(N_SRC));

  // Switch FSM state register together with the active and pending selects
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SRC_RUN;
      active_q <= DEF_SEL;
      pend_q   <= DEF_SEL;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state logic: track the latest request, cancel on return, commit at sof
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    case (state_q)
      SRC_RUN: begin
        if (req_valid && (sel_req != active_q)) begin
          state_d = SRC_PEND;
          pend_d  = sel_req;
        end
      end
      SRC_PEND: begin
        if (sb_in.sof) begin
`ifdef VID_SRC_SWITCH_BLANK_EN
          state_d = SRC_BLANK;
`else
          state_d  = SRC_RUN;
          active_d = pend_q;
`endif
        end else if (req_valid) begin
          pend_d = sel_req;
          if (sel_req == active_q) state_d = SRC_RUN;
        end
      end
`ifdef VID_SRC_SWITCH_BLANK_EN
      SRC_BLANK: begin
        if (sb_in.sof) begin
          state_d  = SRC_RUN;
          active_d = pend_q;
        end
      end
`endif
      default: state_d = SRC_RUN;
    endcase
  end

  // Outputs: the pixel mux looks at the next-state selects so a commit or
  // the start of a black frame already applies to the sof pixel itself
  always_comb begin
    pending_o = (state_q != SRC_RUN);
    blank_now = 1'b0;
`ifdef VID_SRC_SWITCH_BLANK_EN
    blank_now = (state_d == SRC_BLANK);
`endif
    px_next = (sb_in.de && !blank_now) ? px_in[active_d] : '0;
  end

  // Register the selected pixel; outside active video it is forced to zero
  always_ff @(posedge clk) begin
    if (rst) px_out <= '0;
    else     px_out <= px_next;
  end

  // Free-running sof counter, independent of the switch state
  always_ff @(posedge clk) begin
    if (rst)            frame_cnt_q <= '0;
    else if (sb_in.sof) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  vid_sync_delay #(
    .W   (2),
    .LAT (SRC_SWITCH_LAT)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hs_i, vs_i}),
    .q   (sync_dly)
  );

  vid_sync_delay #(
    .W   (SBW),
    .LAT (SRC_SWITCH_LAT)
  ) u_sb_dly (
    .clk (clk),
    .rst (rst),
    .d   ({sb_in.de, sb_in.x, sb_in.y, sb_in.sof, sb_in.eol}),
    .q   (sb_dly)
  );

  assign {hs_o, vs_o} = sync_dly;
  assign {sb_out.de, sb_out.x, sb_out.y, sb_out.sof, sb_out.eol} = sb_dly;
  assign active_sel_o = active_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_vid_src_switch.sv
// Self-checking bench for vid_src_switch: a 4-source and a 3-source instance
// share one randomized video stream and are compared every cycle against a
// frame-level reference model. Follows VID_SRC_SWITCH_BLANK_EN when defined.
module tb_vid_src_switch;
  import vid_src_switch_pkg::*;

  localparam int XW      = 10;
  localparam int YW      = 9;
  localparam int DEF_SRC = 2;
  localparam int HTOT    = 16;
  localparam int HACT    = 12;
  localparam int VTOT    = 8;
  localparam int VACT    = 6;
  localparam int FRAME   = HTOT * VTOT;
`ifdef VID_SRC_SWITCH_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  pixel_t px_in4 [4];
  pixel_t px_in3 [3];
  logic hs_i, vs_i;
  logic [1:0] sel_req;

  pixel_t px_out4, px_out3;
  logic hs_o4, vs_o4, hs_o3, vs_o3;
  logic [1:0] active4, active3;
  logic pending4, pending3;
  logic [15:0] fcnt4, fcnt3;

  vid_sideband_if #(.XW(XW), .YW(YW)) sb_in ();
  vid_sideband_if #(.XW(XW), .YW(YW)) sb_out4 ();
  vid_sideband_if #(.XW(XW), .YW(YW)) sb_out3 ();

  always #5 clk = ~clk;

  vid_src_switch #(.N_SRC(4), .XW(XW), .YW(YW), .DEF_SRC(DEF_SRC)) dut4 (
    .clk(clk), .rst(rst), .px_in(px_in4), .sb_in(sb_in), .hs_i(hs_i), .vs_i(vs_i),
    .sel_req(sel_req), .px_out(px_out4), .sb_out(sb_out4), .hs_o(hs_o4), .vs_o(vs_o4),
    .active_sel_o(active4), .pending_o(pending4), .frame_cnt_o(fcnt4)
  );

  vid_src_switch #(.N_SRC(3), .XW(XW), .YW(YW), .DEF_SRC(DEF_SRC)) dut3 (
    .clk(clk), .rst(rst), .px_in(px_in3), .sb_in(sb_in), .hs_i(hs_i), .vs_i(vs_i),
    .sel_req(sel_req), .px_out(px_out3), .sb_out(sb_out3), .hs_o(hs_o3), .vs_o(vs_o3),
    .active_sel_o(active3), .pending_o(pending3), .frame_cnt_o(fcnt3)
  );

  int n_checks;
  int n_errors;
  int hc, vc;
  pixel_t last_px [4];

  // Reference model state, index 0 = 4-source instance, 1 = 3-source instance
  int     m_act [2];
  int     m_tgt [2];
  bit     m_pend [2];
  bit     m_blank [2];
  int     m_cnt [2];
  pixel_t exp_px [2];
  logic [XW+YW+2:0] exp_sb;
  logic exp_hs, exp_vs;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock of the switch as seen from the outside: a requested source is
  // remembered until the next frame start, then it becomes visible from that
  // frame's first pixel (or after one black frame when blanking is enabled)
  task automatic modelStep(input int k, input int n_src, input bit r, input bit de, input bit sof);
    int sel;
    bit valid;
    sel   = int'(sel_req);
    valid = (sel < n_src);
    if (r) begin
      m_act[k] = DEF_SRC; m_tgt[k] = DEF_SRC;
      m_pend[k] = 1'b0;   m_blank[k] = 1'b0;
      m_cnt[k] = 0;       exp_px[k] = '0;
    end else begin
      if (sof) m_cnt[k] = (m_cnt[k] + 1) % 65536;
      if (m_blank[k]) begin
        if (sof) begin
          m_act[k] = m_tgt[k];
          m_blank[k] = 1'b0;
        end
      end else if (m_pend[k]) begin
        if (sof) begin
          m_pend[k] = 1'b0;
          if (BLANK_EN) m_blank[k] = 1'b1;
          else          m_act[k] = m_tgt[k];
        end else if (valid) begin
          m_tgt[k] = sel;
          if (sel == m_act[k]) m_pend[k] = 1'b0;
        end
      end else if (valid && sel != m_act[k]) begin
        m_pend[k] = 1'b1;
        m_tgt[k]  = sel;
      end
      exp_px[k] = (de && !m_blank[k]) ? px_in4[m_act[k]] : '0;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit de, input int x, input int y,
                               input bit sof, input bit eol, input bit hs, input bit vs);
    rst = r;
    for (int i = 0; i < 4; i++) begin
      px_in4[i] = pixel_t'($urandom);
      last_px[i] = px_in4[i];
    end
    for (int i = 0; i < 3; i++) px_in3[i] = px_in4[i];
    sb_in.de = de; sb_in.x = XW'(x); sb_in.y = YW'(y);
    sb_in.sof = sof; sb_in.eol = eol;
    hs_i = hs; vs_i = vs;
    modelStep(0, 4, r, de, sof);
    modelStep(1, 3, r, de, sof);
    exp_sb = r ? '0 : {de, XW'(x), YW'(y), sof, eol};
    exp_hs = r ? 1'b0 : hs;
    exp_vs = r ? 1'b0 : vs;
    @(posedge clk);
    #1;
    checkOutput("px4", px_out4, exp_px[0]);
    checkOutput("px3", px_out3, exp_px[1]);
    checkOutput("act4", active4, m_act[0]);
    checkOutput("act3", active3, m_act[1]);
    checkOutput("pend4", pending4, m_pend[0] || m_blank[0]);
    checkOutput("pend3", pending3, m_pend[1] || m_blank[1]);
    checkOutput("fcnt4", fcnt4, m_cnt[0]);
    checkOutput("fcnt3", fcnt3, m_cnt[1]);
    checkOutput("sb4", {sb_out4.de, sb_out4.x, sb_out4.y, sb_out4.sof, sb_out4.eol}, exp_sb);
    checkOutput("sb3", {sb_out3.de, sb_out3.x, sb_out3.y, sb_out3.sof, sb_out3.eol}, exp_sb);
    checkOutput("hsvs4", {hs_o4, vs_o4}, {exp_hs, exp_vs});
    checkOutput("hsvs3", {hs_o3, vs_o3}, {exp_hs, exp_vs});
  endtask

  task automatic stepTiming(input bit r);
    bit de;
    de = (hc < HACT) && (vc < VACT);
    applyStimulus(r, de, hc, vc, de && hc == 0 && vc == 0, de && hc == HACT - 1,
                  hc == 13, vc == VTOT - 1 && hc == 0);
    hc++;
    if (hc == HTOT) begin
      hc = 0;
      vc = (vc + 1) % VTOT;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepTiming(1'b0);
  endtask

  task automatic runUntil(input int v, input int h);
    for (int i = 0; i < FRAME && !(vc == v && hc == h); i++) stepTiming(1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    hc = 0; vc = 0;
    sel_req = 2'd2;

    // Reset state
    for (int i = 0; i < 3; i++) stepTiming(1'b1);
    checkOutput("rst_act", active4, 2);
    checkOutput("rst_px", px_out4, 0);
    checkOutput("rst_fcnt", fcnt4, 0);
    checkOutput("rst_pend", pending4, 0);

    // Mid-frame switch 2 -> 0 waits for sof
    runCycles(2 * FRAME);
    runUntil(3, 5);
    sel_req = 2'd0;
    stepTiming(1'b0);
    checkOutput("t2_pend", pending4, 1);
    runUntil(0, 0);
    checkOutput("t2_still2", active4, 2);
    checkOutput("t2_pend_sof", pending4, 1);
    stepTiming(1'b0);
    checkOutput("t2_sof_px", px_out4, BLANK_EN ? 0 : last_px[0]);
    if (BLANK_EN) begin runUntil(0, 0); stepTiming(1'b0); end
    checkOutput("t2_act", active4, 0);
    checkOutput("t2_done", pending4, 0);

    // Request and withdraw within one frame: no switch
    runUntil(2, 3);
    sel_req = 2'd1;
    runCycles(20);
    sel_req = 2'd0;
    runCycles(5);
    checkOutput("t3_cancel", pending4, 0);
    runUntil(0, 0);
    stepTiming(1'b0);
    checkOutput("t3_nosw", active4, 0);

    // Last request wins; the 3-source instance ignores the invalid 3
    runUntil(2, 3);
    sel_req = 2'd1;
    runCycles(10);
    sel_req = 2'd3;
    runCycles(10);
    checkOutput("t3_pend3", pending3, 1);
    runUntil(0, 0);
    stepTiming(1'b0);
    if (BLANK_EN) begin runUntil(0, 0); stepTiming(1'b0); end
    checkOutput("t3_last4", active4, 3);
    checkOutput("t3_last3", active3, 1);
    runCycles(40);
    checkOutput("t4_inv_act", active3, 1);
    checkOutput("t4_inv_pend", pending3, 0);

    // Reset while a request is pending returns to the default source
    runUntil(3, 0);
    sel_req = 2'd0;
    runCycles(5);
    checkOutput("rp_pend", pending4, 1);
    sel_req = 2'd2;
    stepTiming(1'b1);
    checkOutput("rp_act", active4, 2);
    checkOutput("rp_pend0", pending4, 0);
    runCycles(FRAME);

    // Reset shortly after a committed switch (inside the black frame when enabled)
    sel_req = 2'd1;
    runUntil(0, 0);
    stepTiming(1'b0);
    runCycles(30);
    sel_req = 2'd2;
    stepTiming(1'b1);
    runUntil(0, 0);
    stepTiming(1'b0);
    checkOutput("rb_px", px_out4, last_px[2]);
    checkOutput("rb_act", active4, 2);

    // Randomized requests with occasional resets
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 23) == 0) sel_req = 2'($urandom_range(0, 3));
      stepTiming($urandom_range(0, 999) == 0);
    end

    // Counter wrap: a burst of sof-only cycles runs the 16-bit counter past 0xFFFF
    for (int i = 0; i < 65536 + 8; i++) begin
      if ($urandom_range(0, 4095) == 0) sel_req = 2'($urandom_range(0, 3));
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    runCycles(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
